// File: rtl/conv3x3_pkg.sv
// Shared kernel tables, kernel-select encoding and width helpers for conv3x3_stream.
package conv3x3_pkg;

    localparam int unsigned KERN_BW   = 8;
    localparam int unsigned NUM_KERNS = 4;

    typedef enum logic [1:0] {
        KERN_IDENTITY  = 2'd0,
        KERN_GAUSSIAN  = 2'd1,
        KERN_SHARPEN   = 2'd2,
        KERN_LAPLACIAN = 2'd3
    } kern_sel_e;

    typedef logic signed [KERN_BW-1:0] coef_t;
    typedef coef_t kernel_t [0:2][0:2];

    // Row-major coefficients, indexed by kern_sel_e.
    localparam kernel_t KERNELS [0:NUM_KERNS-1] = '{
        '{'{ 8'sd0,  8'sd0,  8'sd0}, '{ 8'sd0,  8'sd1,  8'sd0}, '{ 8'sd0,  8'sd0,  8'sd0}},
        '{'{ 8'sd1,  8'sd2,  8'sd1}, '{ 8'sd2,  8'sd4,  8'sd2}, '{ 8'sd1,  8'sd2,  8'sd1}},
        '{'{ 8'sd0, -8'sd1,  8'sd0}, '{-8'sd1,  8'sd5, -8'sd1}, '{ 8'sd0, -8'sd1,  8'sd0}},
        '{'{-8'sd1, -8'sd1, -8'sd1}, '{-8'sd1,  8'sd8, -8'sd1}, '{-8'sd1, -8'sd1, -8'sd1}}
    };

    localparam int unsigned SHIFTS [0:NUM_KERNS-1] = '{0, 4, 0, 0};

    // Nine products of PW+BW+1 bits need four extra bits of headroom.
    function automatic int unsigned sum_width(input int unsigned pw, input int unsigned bw);
        return pw + bw + 5;
    endfunction

endpackage

// File: rtl/conv3x3_window.sv
// Two line buffers plus 3x3 window; taps_o presents the window as it becomes once pixel_i is shifted in.
module conv3x3_window #(
    parameter int unsigned WIDTH = 320,
    parameter int unsigned PIX_W = 30
) (
    input  logic                   clk,
    input  logic                   shift_en_i,
    input  logic [PIX_W-1:0]       pixel_i,
    output logic [8:0][PIX_W-1:0]  taps_o
);

    logic [WIDTH-1:0][PIX_W-1:0] lb1_q;
    logic [WIDTH-1:0][PIX_W-1:0] lb2_q;
    logic [8:0][PIX_W-1:0]       win_q;

    // Tap r*3+c: row 0 is oldest line, column 0 is oldest pixel; heads of the line buffers feed column 2.
    always_comb begin
        taps_o = win_q;
        for (int r = 0; r < 3; r++) begin
            taps_o[r*3]   = win_q[r*3+1];
            taps_o[r*3+1] = win_q[r*3+2];
        end
        taps_o[2] = lb2_q[WIDTH-1];
        taps_o[5] = lb1_q[WIDTH-1];
        taps_o[8] = pixel_i;
    end

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            win_q <= taps_o;
            lb1_q <= {lb1_q[WIDTH-2:0], pixel_i};
            lb2_q <= {lb2_q[WIDTH-2:0], lb1_q[WIDTH-1]};
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolver for packed multi-channel pixels with ready/valid flow control.
// Build option CONV3X3_ABS_EN: negative sums output their magnitude instead of clamping to zero.
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned CH     = 3,
    parameter int unsigned CW     = 10,
    parameter int unsigned PW     = 8,
    parameter int unsigned BW     = KERN_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         kern_sel,
    input  logic [CH*CW-1:0]   x_data,
    input  logic               x_valid,
    output logic               x_ready,
    output logic [CH*CW-1:0]   y_data,
    output logic               y_valid,
    input  logic               y_ready,
    output logic               primed
);

    localparam int unsigned W       = CH * CW;
    localparam int unsigned OP_W    = PW + 1;
    localparam int unsigned PROD_W  = PW + BW + 1;
    localparam int unsigned SUM_W   = sum_width(PW, BW);
    localparam int unsigned COL_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned PRIME_W = $clog2(WIDTH + 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((2 ** PW) - 1);

    logic                 y_valid_q, y_valid_d;
    logic [W-1:0]         y_data_q,  y_data_d;
    logic                 primed_q,  primed_d;
    logic [PRIME_W-1:0]   prime_cnt_q, prime_cnt_d;
    logic [COL_W-1:0]     ccol_q, ccol_d;
    logic [ROW_W-1:0]     crow_q, crow_d;
    kern_sel_e            active_q, active_d;

    logic                 accept_c;
    logic                 border_c;
    logic [8:0][W-1:0]    taps;
    logic [W-1:0]         result_c;

    logic signed [OP_W-1:0]   operand;
    logic signed [BW-1:0]     coef;
    logic signed [PROD_W-1:0] product;
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  shifted;
    logic        [PW-1:0]     pix;

    assign x_ready  = y_ready | ~y_valid_q;
    assign accept_c = x_valid & x_ready;
    assign y_valid  = y_valid_q;
    assign y_data   = y_data_q;
    assign primed   = primed_q;

    conv3x3_window #(
        .WIDTH (WIDTH),
        .PIX_W (W)
    ) u_window (
        .clk        (clk),
        .shift_en_i (accept_c & ~reset),
        .pixel_i    (x_data),
        .taps_o     (taps)
    );

    assign border_c = (ccol_q == '0) || (ccol_q == COL_W'(WIDTH - 1)) ||
                      (crow_q == '0) || (crow_q == ROW_W'(HEIGHT - 1));

    // Per-channel MAC, floor shift and clamp; border centres pass through with low bits dropped.
    always_comb begin
        operand  = '0;
        coef     = '0;
        product  = '0;
        acc      = '0;
        shifted  = '0;
        pix      = '0;
        result_c = '0;
        for (int ch = 0; ch < CH; ch++) begin
            acc = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    operand = {1'b0, taps[r*3+c][W-1-ch*CW -: PW]};
                    coef    = BW'(KERNELS[active_q][r][c]);
                    product = PROD_W'(operand) * PROD_W'(coef);
                    acc     = acc + SUM_W'(product);
                end
            end
            shifted = acc >>> SHIFTS[active_q];
`ifdef CONV3X3_ABS_EN
            if (shifted[SUM_W-1]) shifted = -shifted;
`endif
            if (shifted[SUM_W-1])       pix = '0;
            else if (shifted > PIX_MAX) pix = '1;
            else                        pix = shifted[PW-1:0];
            if (border_c) pix = taps[4][W-1-ch*CW -: PW];
            result_c[W-1-ch*CW -: CW] = CW'(pix) << (CW - PW);
        end
    end

    // Priming, centre position tracking, frame-origin kernel latch and output register load.
    always_comb begin
        y_valid_d   = y_valid_q;
        y_data_d    = y_data_q;
        primed_d    = primed_q;
        prime_cnt_d = prime_cnt_q;
        ccol_d      = ccol_q;
        crow_d      = crow_q;
        active_d    = active_q;
        if (y_ready) y_valid_d = 1'b0;
        if (accept_c) begin
            if (!primed_q) begin
                if (prime_cnt_q == PRIME_W'(WIDTH)) primed_d = 1'b1;
                else                                prime_cnt_d = prime_cnt_q + PRIME_W'(1);
            end else begin
                y_valid_d = 1'b1;
                y_data_d  = result_c;
                if (ccol_q == '0 && crow_q == '0) active_d = kern_sel_e'(kern_sel);
                if (ccol_q == COL_W'(WIDTH - 1)) begin
                    ccol_d = '0;
                    crow_d = (crow_q == ROW_W'(HEIGHT - 1)) ? '0 : crow_q + ROW_W'(1);
                end else begin
                    ccol_d = ccol_q + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_valid_q   <= 1'b0;
            y_data_q    <= '0;
            primed_q    <= 1'b0;
            prime_cnt_q <= '0;
            ccol_q      <= '0;
            crow_q      <= '0;
            active_q    <= KERN_IDENTITY;
        end else begin
            y_valid_q   <= y_valid_d;
            y_data_q    <= y_data_d;
            primed_q    <= primed_d;
            prime_cnt_q <= prime_cnt_d;
            ccol_q      <= ccol_d;
            crow_q      <= crow_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on an 8x6 frame: vector table, corner sequences and random traffic vs an image model.
module tb_conv3x3_stream;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 6;
    localparam int CH     = 3;
    localparam int CW     = 10;
    localparam int PW     = 8;
    localparam int BW     = 8;
    localparam int W      = CH * CW;
    localparam int FRAME  = WIDTH * HEIGHT;
    localparam int PRIME  = WIDTH + 1;
`ifdef CONV3X3_ABS_EN
    localparam int ABS_ON = 1;
`else
    localparam int ABS_ON = 0;
`endif

    typedef logic [W-1:0] pix_t;
    typedef struct {
        int kern;
        int ctr;
        int nb;
        int expv;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] kern_sel;
    pix_t       x_data;
    logic       x_valid;
    logic       x_ready;
    pix_t       y_data;
    logic       y_valid;
    logic       y_ready;
    logic       primed;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .WIDTH (WIDTH), .HEIGHT (HEIGHT), .CH (CH), .CW (CW), .PW (PW), .BW (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .kern_sel (kern_sel),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .primed   (primed)
    );

    pix_t pix_q[$];
    pix_t exp_q[$];
    pix_t dut_out[$];
    int   n_acc, n_out, n_checks, n_fail, kern_m;
    logic stall_q;
    pix_t stall_data;

    int kcoef [4][9] = '{'{ 0,  0,  0,  0, 1,  0,  0,  0,  0},
                         '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
                         '{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
                         '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};
    int kshift [4] = '{0, 4, 0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or data missing", name);
    endtask

    function automatic pix_t mk(input int v0, input int v1, input int v2, input int lo);
        return {8'(v0), 2'(lo), 8'(v1), 2'(lo), 8'(v2), 2'(lo)};
    endfunction

    function automatic int top8(input pix_t p, input int ch);
        pix_t s;
        s = p >> (W - (ch + 1) * CW + (CW - PW));
        return int'(s & pix_t'(255));
    endfunction

    // Expected output for the k-th centre pixel since reset, from the stored image.
    function automatic pix_t ref_pixel(input int k);
        int col, row, s;
        int v [3];
        col = k % WIDTH;
        row = (k / WIDTH) % HEIGHT;
        for (int ch = 0; ch < 3; ch++) begin
            if (col == 0 || col == WIDTH - 1 || row == 0 || row == HEIGHT - 1) begin
                v[ch] = top8(pix_q[k], ch);
            end else begin
                s = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        s += kcoef[kern_m][(dr + 1) * 3 + dc + 1] * top8(pix_q[k + dr * WIDTH + dc], ch);
                s = s >>> kshift[kern_m];
                if (ABS_ON != 0 && s < 0) s = -s;
                if (s < 0)   s = 0;
                if (s > 255) s = 255;
                v[ch] = s;
            end
        end
        return mk(v[0], v[1], v[2], 0);
    endfunction

    task automatic model_clear();
        pix_q.delete();
        exp_q.delete();
        dut_out.delete();
        n_acc   = 0;
        n_out   = 0;
        kern_m  = 0;
        stall_q = 1'b0;
    endtask

    // One clock: drive after the falling edge, observe 1ns later, let the rising edge happen.
    task automatic cycle(input logic xv, input pix_t xd, input logic yr, input logic rst);
        pix_t e;
        int   k;
        x_valid = xv;
        x_data  = xd;
        y_ready = yr;
        reset   = rst;
        #1;
        if (stall_q) begin
            check("stall_valid_held", y_valid, 1'b1);
            check("stall_data_held", y_data, stall_data);
        end
        stall_q = 1'b0;
        if (rst) begin
            model_clear();
        end else begin
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("y_data[%0d]", n_out), y_data, e);
                end
                dut_out.push_back(y_data);
                n_out++;
            end
            if (y_valid && !y_ready) begin
                stall_q    = 1'b1;
                stall_data = y_data;
            end
            if (x_valid && x_ready) begin
                pix_q.push_back(xd);
                n_acc++;
                if (pix_q.size() > PRIME) begin
                    k = pix_q.size() - PRIME - 1;
                    if (k % FRAME == 0) kern_m = int'(kern_sel);
                    exp_q.push_back(ref_pixel(k));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic feed(input int target, input int mode, input pix_t c);
        int   budget;
        pix_t d;
        budget = 500;
        while (n_acc < target && budget > 0) begin
            d = (mode == 0) ? c : pix_t'($urandom);
            cycle(1'b1, d, 1'b1, 1'b0);
            budget--;
        end
        if (n_acc < target) fail_now("feed_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("out_count", n_out, (n_acc > PRIME) ? n_acc - PRIME : 0);
    endtask

    vec_t vecs [9];
    int   cyc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        kern_sel = 2'd0;
        x_valid  = 1'b0;
        x_data   = '0;
        y_ready  = 1'b1;
        reset    = 1'b1;
        model_clear();

        vecs = '{'{1, 100, 100, 100},
                 '{2, 200,   0, 255},
                 '{2,   0, 200, (ABS_ON != 0) ? 255 : 0},
                 '{3,  50,  50,   0},
                 '{0,  77,  13,  77},
                 '{1, 255,   0,  63},
                 '{3,  10,  20, (ABS_ON != 0) ? 80 : 0},
                 '{2, 100,  90, 140},
                 '{1,   0, 255, 191}};

        @(negedge clk);
        do_reset();
        check("reset_y_valid", y_valid, 1'b0);
        check("reset_y_data", y_data, '0);
        check("reset_primed", primed, 1'b0);
        check("reset_x_ready", x_ready, 1'b1);

        // Priming: nine silent accepts, tenth produces the first (border) output.
        do_reset();
        kern_sel = 2'd1;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 30'h3FCFF3FC, 1'b1, 1'b0);
            if (i < 10) begin
                check("prime_no_valid", y_valid, 1'b0);
                check("primed_flag", primed, (i == 9));
            end else begin
                check("first_valid", y_valid, 1'b1);
                check("first_data", y_data, 30'h3FCFF3FC);
            end
        end
        drain();

        // Vector table: uniform neighbourhood with one distinct centre at row 2, col 3.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            kern_sel = 2'(vecs[i].kern);
            for (int n = 0; n < 30; n++)
                feed(n + 1, 0, (n == 19) ? mk(vecs[i].ctr, vecs[i].ctr, vecs[i].ctr, 3)
                                         : mk(vecs[i].nb, vecs[i].nb, vecs[i].nb, 3));
            drain();
            if (dut_out.size() > 19)
                check($sformatf("vec%0d_centre", i), dut_out[19], mk(vecs[i].expv, vecs[i].expv, vecs[i].expv, 0));
            else
                fail_now($sformatf("vec%0d_centre", i));
        end

        // Backpressure: output stalled for 5 cycles while upstream keeps offering.
        do_reset();
        kern_sel = 2'd2;
        feed(20, 1, '0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, pix_t'($urandom), 1'b0, 1'b0);
            check("bp_x_ready", x_ready, 1'b0);
            check("bp_y_valid", y_valid, 1'b1);
        end
        check("bp_no_accept", n_acc, 20);
        feed(40, 1, '0);
        drain();

        // Kernel latch: switch to laplacian mid-frame; identity holds until the next frame origin.
        do_reset();
        kern_sel = 2'd0;
        for (int n = 0; n < 70; n++) begin
            if (n_acc >= 29) kern_sel = 2'd3;
            feed(n + 1, 0, mk(60, 60, 60, 1));
        end
        drain();
        if (dut_out.size() > 57) begin
            check("latch_identity_mid", dut_out[27], mk(60, 60, 60, 0));
            check("latch_identity_late", dut_out[38], mk(60, 60, 60, 0));
            check("latch_laplacian_next", dut_out[57], mk(0, 0, 0, 0));
        end else begin
            fail_now("latch_outputs");
        end

        // Reset mid-frame while upstream is offering a pixel.
        do_reset();
        kern_sel = 2'd1;
        feed(20, 1, '0);
        cycle(1'b1, pix_t'($urandom), 1'b1, 1'b1);
        check("midrst_y_valid", y_valid, 1'b0);
        check("midrst_primed", primed, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            feed(i, 1, '0);
            check("reprime_no_valid", y_valid, 1'b0);
        end
        check("reprime_primed", primed, 1'b1);
        feed(30, 1, '0);
        drain();

        // Random traffic, random stalls and kern_sel changes over several frames.
        do_reset();
        cyc = 0;
        while (n_acc < 4 * FRAME && cyc < 5000) begin
            kern_sel = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) != 0, pix_t'($urandom), $urandom_range(0, 2) != 0, 1'b0);
            cyc++;
        end
        if (n_acc < 4 * FRAME) fail_now("random_timeout");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
